dispatcher_cpuid_alloc: RTL and testbench

Parametrised CPU-thread allocator for the OpenFlow pipeline dispatcher. It generalises the fixed 32-thread round-robin/port-bind allocator in three ways: the thread count is a parameter, it adds a flow-hash mode, and it tracks per-thread outstanding-packet credits so that saturated threads are skipped. It sits between the dispatcher input stage, which requests a cpuid per packet head, and the RDMA output path, which returns credits when a thread consumes a packet.

---
 rtl/dispatcher_pkg.sv | 20 ++
 rtl/dispatcher_rr_search.sv | 33 +++
 rtl/dispatcher_cpuid_alloc.sv | 171 +++++++++++++++++
 tb/tb_dispatcher_cpuid_alloc.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// Shared definitions for the OpenFlow dispatcher stages: allocation modes and
// the layout of the 134-bit packet word that flows between stages.
package dispatcher_pkg;

  typedef enum logic [1:0] {
    MODE_RR   = 2'd0,
    MODE_BIND = 2'd1,
    MODE_HASH = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int PKT_W      = 134;
  localparam int PKT_HEAD_B = 133;
  localparam int PKT_TAIL_B = 132;
  localparam int PKT_INV_HI = 131;
  localparam int PKT_INV_LO = 128;

  typedef logic [PKT_W-1:0] pkt_word_t;

endpackage

// File: rtl/dispatcher_rr_search.sv
// Rotating-priority finder: first set bit of elig at or after start, wrapping
// at chan. A start at or beyond chan restarts the scan at thread 0.
module dispatcher_rr_search #(
  parameter int NUM_THREADS = 32,
  parameter int ID_W        = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] elig,
  input  logic [ID_W-1:0]        start,
  input  logic [ID_W:0]          chan,
  output logic                   found,
  output logic [ID_W-1:0]        idx
);

  logic [ID_W:0]   base;
  logic [ID_W+1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    base  = ({1'b0, start} >= chan) ? '0 : {1'b0, start};
    for (int k = 0; k < NUM_THREADS; k++) begin
      // base < chan and k < chan, so one subtraction completes the wrap
      cand = {1'b0, base} + (ID_W+2)'(k);
      if (cand >= {1'b0, chan}) cand = cand - {1'b0, chan};
      if (!found && ((ID_W+1)'(k) < chan) && elig[cand[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dispatcher_cpuid_alloc.sv
// CPU-thread allocator: round-robin, port-bind and flow-hash grant modes with
// per-thread outstanding-packet credits; responds one cycle after each request.
module dispatcher_cpuid_alloc
  import dispatcher_pkg::*;
#(
  parameter int NUM_THREADS = 32,
  parameter int ID_W        = $clog2(NUM_THREADS),
  parameter int KEY_W       = 16,
  parameter int MAX_OUT     = 8,
  parameter int CNT_W       = $clog2(MAX_OUT+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             in_mode,
  input  logic [ID_W:0]          in_channel_num,
  input  logic [NUM_THREADS-1:0] in_cpuid_mask,
  input  logic                   in_req,
  input  logic [KEY_W-1:0]       in_req_key,
  output logic                   out_ack,
  output logic [ID_W-1:0]        out_cpuid,
  output logic                   out_cpuid_valid,
  input  logic                   in_release,
  input  logic [ID_W-1:0]        in_release_id,
  output logic [NUM_THREADS-1:0] out_thread_full,
  output logic                   out_underflow_err
);

  localparam int HASH_SL = (KEY_W + ID_W - 1) / ID_W;
  localparam int TGT_N   = 1 << ID_W;

  logic [NUM_THREADS-1:0][CNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   ack_q, ack_d;
  logic [ID_W-1:0]        cpuid_q, cpuid_d;
  logic                   valid_q, valid_d;
  logic [NUM_THREADS-1:0] full_q, full_d;
  logic                   uerr_q, uerr_d;

  logic [NUM_THREADS-1:0] elig;
  logic [TGT_N-1:0]       elig_pad;
  logic [ID_W:0]          chan_eff;
  logic [ID_W-1:0]        fold;
  logic [ID_W-1:0]        hash_tgt;
  logic [ID_W-1:0]        bind_tgt;
  logic [ID_W-1:0]        srch_start;
  logic                   srch_found;
  logic [ID_W-1:0]        srch_idx;
  logic                   grant;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W:0]          rr_nxt;

  function automatic logic [ID_W-1:0] hash_fold(input logic [KEY_W-1:0] key);
    logic [HASH_SL*ID_W-1:0] padded;
    logic [ID_W-1:0]         acc;
    padded = (HASH_SL*ID_W)'(key);
    acc    = '0;
    for (int s = 0; s < HASH_SL; s++) acc = acc ^ padded[s*ID_W +: ID_W];
    return acc;
  endfunction

  // Threads past NUM_THREADS do not exist, so the scan range is clamped
  always_comb begin
    chan_eff = (in_channel_num > (ID_W+1)'(NUM_THREADS)) ?
               (ID_W+1)'(NUM_THREADS) : in_channel_num;
    for (int i = 0; i < NUM_THREADS; i++) begin
      elig[i] = in_cpuid_mask[i] && ((ID_W+1)'(i) < in_channel_num) &&
                (count_q[i] < CNT_W'(MAX_OUT));
    end
    elig_pad = TGT_N'(elig);
  end

  always_comb begin
    fold     = hash_fold(in_req_key);
    hash_tgt = ({1'b0, fold} >= in_channel_num) ? (fold - in_channel_num[ID_W-1:0]) : fold;
    bind_tgt = in_req_key[ID_W-1:0];
    srch_start = (mode_e'(in_mode) == MODE_HASH) ? hash_tgt : rr_ptr_q;
  end

  dispatcher_rr_search #(
    .NUM_THREADS (NUM_THREADS),
    .ID_W        (ID_W)
  ) u_rr_search (
    .elig  (elig),
    .start (srch_start),
    .chan  (chan_eff),
    .found (srch_found),
    .idx   (srch_idx)
  );

  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    rr_ptr_d = rr_ptr_q;
    rr_nxt   = '0;
    if (in_req) begin
      case (mode_e'(in_mode))
        MODE_BIND: begin
          if (elig_pad[bind_tgt]) begin
            grant    = 1'b1;
            grant_id = bind_tgt;
          end
        end
        MODE_HASH: begin
          // Fallback search starts at the hash target and leaves rr_ptr alone
          if (elig_pad[hash_tgt]) begin
            grant    = 1'b1;
            grant_id = hash_tgt;
          end else if (srch_found) begin
            grant    = 1'b1;
            grant_id = srch_idx;
          end
        end
        default: begin
          if (srch_found) begin
            grant    = 1'b1;
            grant_id = srch_idx;
            rr_nxt   = {1'b0, srch_idx} + 1'b1;
            rr_ptr_d = (rr_nxt >= chan_eff) ? '0 : rr_nxt[ID_W-1:0];
          end
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    uerr_d  = uerr_q;
    full_d  = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (in_release && (in_release_id == ID_W'(i)) && (count_q[i] == '0)) uerr_d = 1'b1;
      if (grant && (grant_id == ID_W'(i)) &&
          !(in_release && (in_release_id == ID_W'(i)) && (count_q[i] != '0))) begin
        count_d[i] = count_q[i] + 1'b1;
      end else if (!(grant && (grant_id == ID_W'(i))) &&
                   in_release && (in_release_id == ID_W'(i)) && (count_q[i] != '0)) begin
        count_d[i] = count_q[i] - 1'b1;
      end
      full_d[i] = (count_d[i] == CNT_W'(MAX_OUT));
    end
    ack_d   = in_req;
    cpuid_d = grant_id;
    valid_d = grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      rr_ptr_q <= '0;
      ack_q    <= 1'b0;
      cpuid_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= '0;
      uerr_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      cpuid_q  <= cpuid_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      uerr_q   <= uerr_d;
    end
  end

  assign out_ack           = ack_q;
  assign out_cpuid         = cpuid_q;
  assign out_cpuid_valid   = valid_q;
  assign out_thread_full   = full_q;
  assign out_underflow_err = uerr_q;

endmodule

// File: tb/tb_dispatcher_cpuid_alloc.sv
// Directed and randomized bench for dispatcher_cpuid_alloc against a
// behavioural allocator model (32 threads, 2 credits per thread).
module tb_dispatcher_cpuid_alloc;

  localparam int NT  = 32;
  localparam int IDW = 5;
  localparam int KW  = 16;
  localparam int MO  = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [1:0]     in_mode = '0;
  logic [IDW:0]   in_channel_num = '0;
  logic [NT-1:0]  in_cpuid_mask = '0;
  logic           in_req = 1'b0;
  logic [KW-1:0]  in_req_key = '0;
  logic           out_ack;
  logic [IDW-1:0] out_cpuid;
  logic           out_cpuid_valid;
  logic           in_release = 1'b0;
  logic [IDW-1:0] in_release_id = '0;
  logic [NT-1:0]  out_thread_full;
  logic           out_underflow_err;

  dispatcher_cpuid_alloc #(
    .NUM_THREADS (NT),
    .KEY_W       (KW),
    .MAX_OUT     (MO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_mode           (in_mode),
    .in_channel_num    (in_channel_num),
    .in_cpuid_mask     (in_cpuid_mask),
    .in_req            (in_req),
    .in_req_key        (in_req_key),
    .out_ack           (out_ack),
    .out_cpuid         (out_cpuid),
    .out_cpuid_valid   (out_cpuid_valid),
    .in_release        (in_release),
    .in_release_id     (in_release_id),
    .out_thread_full   (out_thread_full),
    .out_underflow_err (out_underflow_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: outstanding packets per thread, round-robin pointer as a
  // plain integer, sticky underflow, and the response expected after the edge.
  int m_cnt [NT];
  int m_rr;
  bit m_err;
  bit e_ack;
  bit e_valid;
  int e_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_elig(input int i);
    if (i < 0 || i >= NT) return 1'b0;
    return in_cpuid_mask[i] && (i < int'(in_channel_num)) && (m_cnt[i] < MO);
  endfunction

  function automatic int m_search(input int start, input int chan);
    int s;
    int c;
    s = (start >= chan) ? 0 : start;
    for (int k = 0; k < chan; k++) begin
      c = (s + k) % chan;
      if (m_elig(c)) return c;
    end
    return -1;
  endfunction

  function automatic int m_fold(input logic [KW-1:0] key);
    int r;
    r = 0;
    for (int b = 0; b < KW; b++) if (key[b]) r = r ^ (1 << (b % IDW));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_cnt[i] = 0;
    m_rr = 0; m_err = 1'b0; e_ack = 1'b0; e_valid = 1'b0; e_id = 0;
  endtask

  task automatic model_step();
    int g;
    int t;
    int chan;
    int r;
    bit dec;
    g = -1;
    chan = int'(in_channel_num);
    if (in_req) begin
      case (in_mode)
        2'd1: begin
          t = int'(in_req_key) % (1 << IDW);
          if (m_elig(t)) g = t;
        end
        2'd2: begin
          t = m_fold(in_req_key);
          if (t >= chan) t = t - chan;
          g = m_elig(t) ? t : m_search(t, chan);
        end
        default: begin
          g = m_search(m_rr, chan);
          if (g >= 0) m_rr = (g + 1) % chan;
        end
      endcase
    end
    dec = 1'b0;
    r = int'(in_release_id);
    if (in_release && r < NT) begin
      if (m_cnt[r] == 0) m_err = 1'b1;
      else dec = 1'b1;
    end
    if (g >= 0) m_cnt[g]++;
    if (dec) m_cnt[r]--;
    e_ack = in_req;
    e_valid = (g >= 0);
    e_id = (g >= 0) ? g : 0;
  endtask

  task automatic check_all(input string tag);
    logic [NT-1:0] ef;
    for (int i = 0; i < NT; i++) ef[i] = (m_cnt[i] == MO);
    check({tag, "_ack"},   64'(out_ack),           64'(e_ack));
    check({tag, "_valid"}, 64'(out_cpuid_valid),   64'(e_valid));
    check({tag, "_cpuid"}, 64'(out_cpuid),         64'(e_id));
    check({tag, "_full"},  64'(out_thread_full),   64'(ef));
    check({tag, "_uerr"},  64'(out_underflow_err), 64'(m_err));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
    in_req = 1'b0;
    in_release = 1'b0;
  endtask

  task automatic req(input logic [1:0] mode, input logic [KW-1:0] key, input string tag);
    in_mode = mode;
    in_req_key = key;
    in_req = 1'b1;
    tick(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int rr_exp [6];
    int saved_id;
    rr_exp = '{0, 1, 2, 3, 0, 1};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack",   64'(out_ack), 64'd0);
    check("reset_valid", 64'(out_cpuid_valid), 64'd0);
    check("reset_cpuid", 64'(out_cpuid), 64'd0);
    check("reset_full",  64'(out_thread_full), 64'd0);
    check("reset_uerr",  64'(out_underflow_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Round robin over four threads, back to back
    in_cpuid_mask = '1; in_channel_num = 6'd4;
    for (int k = 0; k < 6; k++) begin
      req(2'd0, 16'h0, "rr4");
      check("rr4_id", 64'(out_cpuid), 64'(rr_exp[k]));
      check("rr4_v", 64'(out_cpuid_valid), 64'd1);
    end
    do_reset();

    in_cpuid_mask = 32'b1010;
    req(2'd0, 16'h0, "rrm"); check("rrm_id0", 64'(out_cpuid), 64'd1);
    req(2'd0, 16'h0, "rrm"); check("rrm_id1", 64'(out_cpuid), 64'd3);
    req(2'd0, 16'h0, "rrm"); check("rrm_id2", 64'(out_cpuid), 64'd1);
    do_reset();

    // Credit saturation on a single thread
    in_cpuid_mask = '1; in_channel_num = 6'd1;
    req(2'd0, 16'h0, "sat"); check("sat_v0", 64'(out_cpuid_valid), 64'd1);
    req(2'd0, 16'h0, "sat"); check("sat_v1", 64'(out_cpuid_valid), 64'd1);
    req(2'd0, 16'h0, "sat"); check("sat_v2", 64'(out_cpuid_valid), 64'd0);
    check("sat_full0", 64'(out_thread_full[0]), 64'd1);
    in_release = 1'b1; in_release_id = 5'd0; tick("rel");
    req(2'd0, 16'h0, "sat"); check("sat_v3", 64'(out_cpuid_valid), 64'd1);
    check("sat_id3", 64'(out_cpuid), 64'd0);
    do_reset();

    // Port bind
    in_channel_num = 6'd8;
    req(2'd1, 16'h0005, "bind"); check("bind5", 64'(out_cpuid), 64'd5);
    check("bind5_v", 64'(out_cpuid_valid), 64'd1);
    req(2'd1, 16'h000A, "bind"); check("bind10_v", 64'(out_cpuid_valid), 64'd0);
    in_cpuid_mask[5] = 1'b0;
    req(2'd1, 16'h0005, "bind"); check("bind5m_v", 64'(out_cpuid_valid), 64'd0);
    in_cpuid_mask = '1;
    do_reset();

    // Hash: 0x1234 folds (5-bit slices) to 0x14^0x11^0x04 = 0x01
    in_channel_num = 6'd20;
    req(2'd2, 16'h1234, "hash"); check("hash_id", 64'(out_cpuid), 64'd1);
    in_cpuid_mask[1] = 1'b0;
    req(2'd2, 16'h1234, "hash"); check("hash_fb", 64'(out_cpuid), 64'd2);
    in_cpuid_mask = '1;
    req(2'd0, 16'h0, "hrr"); check("hash_rr", 64'(out_cpuid), 64'd0);
    req(2'd2, 16'h000D, "hash"); check("hash13", 64'(out_cpuid), 64'd13);
    do_reset();

    // Grant and release of the same thread in one cycle
    in_channel_num = 6'd8;
    req(2'd1, 16'h0002, "gr");
    in_release = 1'b1; in_release_id = 5'd2;
    req(2'd1, 16'h0002, "gr"); check("gr_keep", 64'(out_thread_full[2]), 64'd0);
    req(2'd1, 16'h0002, "gr"); check("gr_full", 64'(out_thread_full[2]), 64'd1);
    req(2'd1, 16'h0002, "gr"); check("gr_sat", 64'(out_cpuid_valid), 64'd0);

    // Underflow is sticky
    in_release = 1'b1; in_release_id = 5'd5; tick("uf");
    check("uf_set", 64'(out_underflow_err), 64'd1);
    repeat (3) tick("uf_idle");
    check("uf_hold", 64'(out_underflow_err), 64'd1);

    // Asynchronous reset with a response in flight
    do_reset();
    in_mode = 2'd0; in_req = 1'b1;
    model_step();
    saved_id = e_id;
    @(posedge clk);
    #1;
    check("mid_ack", 64'(out_ack), 64'd1);
    #1 reset = 1'b1;
    #1 model_reset();
    check("mid_ack0", 64'(out_ack), 64'd0);
    check("mid_v0", 64'(out_cpuid_valid), 64'd0);
    check("mid_full0", 64'(out_thread_full), 64'd0);
    @(negedge clk);
    in_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    in_release = 1'b1; in_release_id = 5'(saved_id); tick("stale");
    check("stale_uf", 64'(out_underflow_err), 64'd1);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 40 == 0) begin
        in_channel_num = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 40))
                                                     : 6'($urandom_range(2, 32));
        in_cpuid_mask = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($urandom | $urandom);
      end
      in_mode = 2'($urandom_range(0, 3));
      in_req_key = 16'($urandom);
      in_req = ($urandom_range(0, 9) < 7);
      in_release = ($urandom_range(0, 1) == 1);
      in_release_id = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, 7));
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
